// File: rtl/service_4_game_ctrl.sv
// Alarm-dismiss minigame sequencer: draws a one-hot target, waits for
// cleared switches, then scores held matches against a per-round timeout.
module service_4_game_ctrl #(
  parameter int ROUNDS      = 3,
  parameter int HOLD_CYC    = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [9:0] rnd_hot,
  input  logic [9:0] spdts,
  output logic       rnd_take,
  output logic [9:0] target_led,
  output logic [3:0] round_cnt,
  output logic       playing,
  output logic       fail,
  output logic       game_done
);

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  HLD = 8'(HOLD_CYC - 1);
  localparam logic [7:0]  MRT = 8'(MAX_RETRY);
  localparam logic [3:0]  RND = 4'(ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLR,
    S_PLAY,
    S_DONE
  } state_t;

  state_t      state, state_n;
  logic        start_q;
  logic [15:0] timer, timer_n;
  logic [7:0]  hold, hold_n;
  logic [7:0]  retry, retry_n;
  logic [9:0]  prev, prev_n;
  logic [9:0]  target_n;
  logic [3:0]  cnt_n;
  logic        fail_n;

  logic       rise;
  logic       onehot;
  logic       rep_hit;
  logic       match;
  logic       wrong;
  logic [3:0] cnt_inc;

  assign rise    = start & ~start_q;
  assign onehot  = (rnd_hot != '0) &&
                   ((rnd_hot & (rnd_hot - 10'd1)) == '0);
  assign rep_hit = (rnd_hot == prev) && (retry < MRT);
  assign match   = (spdts == target_led);
  assign wrong   = |(spdts & ~target_led);
  assign cnt_inc = (round_cnt == RND) ? round_cnt
                                      : round_cnt + 4'd1;

  assign rnd_take  = (state == S_LOAD);
  assign game_done = (state == S_DONE);
  assign playing   = (state == S_LOAD) ||
                     (state == S_CLR)  ||
                     (state == S_PLAY);

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    hold_n   = hold;
    retry_n  = retry;
    prev_n   = prev;
    target_n = target_led;
    cnt_n    = round_cnt;
    fail_n   = 1'b0;
    if (playing && !start) begin
      state_n  = S_IDLE;
      timer_n  = '0;
      hold_n   = '0;
      retry_n  = '0;
      target_n = '0;
      cnt_n    = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          target_n = '0;
          cnt_n    = '0;
          if (rise) state_n = S_LOAD;
        end
        S_LOAD: begin
          if (!onehot || rep_hit) begin
            retry_n = (retry == 8'hff) ? retry
                                       : retry + 8'd1;
          end else begin
            target_n = rnd_hot;
            prev_n   = rnd_hot;
            retry_n  = '0;
            state_n  = S_CLR;
          end
        end
        S_CLR: begin
          if (spdts == '0) begin
            timer_n = '0;
            hold_n  = '0;
            state_n = S_PLAY;
          end
        end
        S_PLAY: begin
          timer_n = timer + 16'd1;
          if (match && hold == HLD) begin
            cnt_n   = cnt_inc;
            hold_n  = '0;
            state_n = (cnt_inc == RND) ? S_DONE : S_LOAD;
          end else if (wrong || timer == TMO) begin
            fail_n  = 1'b1;
            cnt_n   = '0;
            hold_n  = '0;
            state_n = S_LOAD;
          end else if (match) begin
            hold_n = hold + 8'd1;
          end else begin
            hold_n = '0;
          end
        end
        S_DONE: begin
          target_n = '0;
          cnt_n    = '0;
          state_n  = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // start_q keeps tracking through reset so a level held across it is no edge
  always_ff @(posedge clk) begin
    start_q <= start;
    if (resetn) begin
      state      <= S_IDLE;
      timer      <= '0;
      hold       <= '0;
      retry      <= '0;
      prev       <= '0;
      target_led <= '0;
      round_cnt  <= '0;
      fail       <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      hold       <= hold_n;
      retry      <= retry_n;
      prev       <= prev_n;
      target_led <= target_n;
      round_cnt  <= cnt_n;
      fail       <= fail_n;
    end
  end

endmodule

// File: tb/tb_service_4_game_ctrl.sv
// Scoreboard bench for the minigame sequencer: directed rounds, retries,
// hold break, wrong switch, timeout tie and abort.
module tb_service_4_game_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [9:0] rnd_hot;
  logic [9:0] spdts;
  logic       rnd_take;
  logic [9:0] target_led;
  logic [3:0] round_cnt;
  logic       playing;
  logic       fail;
  logic       game_done;

  always #5 clk = ~clk;

  service_4_game_ctrl #(
    .ROUNDS(3),
    .HOLD_CYC(4),
    .TIMEOUT_CYC(20),
    .MAX_RETRY(3)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .rnd_hot(rnd_hot),
    .spdts(spdts),
    .rnd_take(rnd_take),
    .target_led(target_led),
    .round_cnt(round_cnt),
    .playing(playing),
    .fail(fail),
    .game_done(game_done)
  );

  typedef struct packed {
    logic       take;
    logic       fl;
    logic       done;
    logic [3:0] cnt;
    logic [9:0] tgt;
  } ev_t;

  ev_t   q[$];
  string nq[$];
  int    npass = 0;
  int    ntot  = 0;
  ev_t   act_ev;
  ev_t   exp_ev;
  string exp_nm;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // event packing: {take, fail, done, cnt[3:0], tgt[9:0]}
  always @(negedge clk) begin
    if (resetn === 1'b0 && (rnd_take | fail | game_done)) begin
      act_ev = {rnd_take, fail, game_done, round_cnt, target_led};
      if (q.size() == 0) begin
        ntot++;
        $display("FAIL unexpected_event: got %h want none", act_ev);
      end else begin
        exp_ev = q.pop_front();
        exp_nm = nq.pop_front();
        chk(exp_nm, 32'(act_ev), 32'(exp_ev));
      end
    end
  end

  task automatic step(logic [9:0] r, logic [9:0] sp);
    rnd_hot = r;
    spdts   = sp;
    @(posedge clk);
    #1;
  endtask

  task automatic se(string nm, logic [9:0] r, logic [9:0] sp,
                    logic t, logic f, logic d,
                    logic [3:0] c, logic [9:0] g);
    q.push_back({t, f, d, c, g});
    nq.push_back(nm);
    step(r, sp);
  endtask

  task automatic hits(int n, logic [9:0] sp);
    for (int i = 0; i < n; i++) step(10'h000, sp);
  endtask

  task automatic load_rep(string nm, logic [9:0] r,
                          logic [3:0] c, logic [9:0] g);
    for (int i = 0; i < 3; i++) se(nm, r, 10'h000, 1, 0, 0, c, g);
    step(r, 10'h000);
  endtask

  initial begin
    resetn  = 1'b1;
    start   = 1'b1;
    rnd_hot = '0;
    spdts   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 32'({rnd_take, fail, game_done, playing,
                          round_cnt, target_led}), 32'd0);
    resetn = 1'b0;
    step(10'h000, 10'h000);
    step(10'h000, 10'h000);
    chk("no_edge_idle", 32'(playing), 32'd0);
    start = 1'b0;
    step(10'h000, 10'h000);
    start = 1'b1;
    se("first_take", 10'h000, 10'h000, 1, 0, 0, 4'd0, 10'h000);

    // happy path, repeated target forces three re-draws per later round
    step(10'h004, 10'h000);
    step(10'h000, 10'h000);
    hits(3, 10'h004);
    se("round1", 10'h000, 10'h004, 1, 0, 0, 4'd1, 10'h004);
    load_rep("retry_r2", 10'h004, 4'd1, 10'h004);
    step(10'h000, 10'h000);
    hits(3, 10'h004);
    se("round2", 10'h000, 10'h004, 1, 0, 0, 4'd2, 10'h004);
    load_rep("retry_r3", 10'h004, 4'd2, 10'h004);
    step(10'h000, 10'h000);
    hits(3, 10'h004);
    se("game_done", 10'h000, 10'h004, 0, 0, 1, 4'd3, 10'h004);
    step(10'h000, 10'h000);
    chk("idle_cnt", 32'(round_cnt), 32'd0);
    chk("idle_tgt", 32'(target_led), 32'd0);
    chk("idle_playing", 32'(playing), 32'd0);
    step(10'h000, 10'h000);

    // hold break
    start = 1'b0;
    step(10'h000, 10'h000);
    start = 1'b1;
    se("reentry", 10'h000, 10'h000, 1, 0, 0, 4'd0, 10'h000);
    step(10'h020, 10'h000);
    step(10'h000, 10'h000);
    hits(3, 10'h020);
    step(10'h000, 10'h000);
    hits(3, 10'h020);
    se("hold_break", 10'h000, 10'h020, 1, 0, 0, 4'd1, 10'h020);

    // wrong switch at round_cnt=2
    step(10'h004, 10'h000);
    step(10'h000, 10'h000);
    hits(3, 10'h004);
    se("cnt2", 10'h000, 10'h004, 1, 0, 0, 4'd2, 10'h004);
    load_rep("rep_reject", 10'h004, 4'd2, 10'h004);
    step(10'h000, 10'h000);
    se("wrong", 10'h000, 10'h006, 1, 1, 0, 4'd0, 10'h004);

    // timeout, then success on the timeout cycle
    step(10'h100, 10'h000);
    step(10'h000, 10'h000);
    hits(3, 10'h100);
    se("pre_tmo", 10'h000, 10'h100, 1, 0, 0, 4'd1, 10'h100);
    step(10'h200, 10'h000);
    step(10'h000, 10'h000);
    hits(19, 10'h000);
    se("timeout", 10'h000, 10'h000, 1, 1, 0, 4'd0, 10'h200);
    step(10'h008, 10'h000);
    step(10'h000, 10'h000);
    hits(16, 10'h000);
    hits(3, 10'h008);
    se("tmo_tie", 10'h000, 10'h008, 1, 0, 0, 4'd1, 10'h008);

    // non-one-hot never accepted, then abort mid-play
    se("nonhot_0", 10'h000, 10'h000, 1, 0, 0, 4'd1, 10'h008);
    se("nonhot_3", 10'h003, 10'h000, 1, 0, 0, 4'd1, 10'h008);
    se("nonhot_r3", 10'h003, 10'h000, 1, 0, 0, 4'd1, 10'h008);
    se("nonhot_r4", 10'h000, 10'h000, 1, 0, 0, 4'd1, 10'h008);
    step(10'h040, 10'h000);
    chk("accept_tgt", 32'(target_led), 32'h040);
    step(10'h000, 10'h000);
    hits(2, 10'h040);
    start = 1'b0;
    step(10'h000, 10'h040);
    chk("abort_outs", 32'({playing, fail, game_done,
                          round_cnt, target_led}), 32'd0);
    repeat (3) step(10'h000, 10'h000);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
